// File: rtl/midi_byte_tx_if.sv
// Byte handshake between a producer and the MIDI byte transmitter.
// data_in/data_valid from producer; data_ready back from transmitter.
interface midi_byte_tx_if;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;

  modport master (
    output data_in,
    output data_valid,
    input  data_ready
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready
  );
endinterface

// File: rtl/midi_byte_tx.sv
// MIDI serial byte transmitter: start bit, 8 data bits LSB first, stop bits.
// Ports: clk, reset (async high), bus (byte handshake), tx (serial), busy.
module midi_byte_tx #(
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter int unsigned STOP_BITS    = 2
) (
  input  logic          clk,
  input  logic          reset,
  midi_byte_tx_if.slave bus,
  output logic          tx,
  output logic          busy
);

  localparam int unsigned TW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [1:0]    S_LAST = 2'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [1:0]    stop_cnt_q, stop_cnt_d;
  logic [7:0]    shifter_q, shifter_d;
  logic [7:0]    hold_q, hold_d;
  logic          hold_full_q, hold_full_d;
  logic          tx_d;
  logic          bit_end;
  logic          load;

  assign bus.data_ready = !hold_full_q;
  assign busy    = (state_q != IDLE) | hold_full_q;
  assign bit_end = (timer_q == T_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      bit_cnt_q   <= '0;
      stop_cnt_q  <= '0;
      shifter_q   <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      tx          <= 1'b1;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      bit_cnt_q   <= bit_cnt_d;
      stop_cnt_q  <= stop_cnt_d;
      shifter_q   <= shifter_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      tx          <= tx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    bit_cnt_d   = bit_cnt_q;
    stop_cnt_d  = stop_cnt_q;
    shifter_d   = shifter_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    tx_d        = tx;
    load        = 1'b0;

    // Accept only into an empty hold; a drain needs it full,
    // so the two never collide on hold_full_d.
    if (bus.data_valid && !hold_full_q) begin
      hold_d      = bus.data_in;
      hold_full_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        tx_d    = 1'b1;
        timer_d = '0;
        load    = hold_full_q;
      end
      START: begin
        if (bit_end) begin
          timer_d   = '0;
          tx_d      = shifter_q[0];
          bit_cnt_d = '0;
          state_d   = DATA;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          timer_d = '0;
          if (bit_cnt_q == 3'd7) begin
            tx_d       = 1'b1;
            stop_cnt_d = '0;
            state_d    = STOP;
          end else begin
            shifter_d = shifter_q >> 1;
            tx_d      = shifter_q[1];
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          timer_d = '0;
          if (stop_cnt_q == S_LAST) begin
            if (hold_full_q) begin
              load = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            stop_cnt_d = stop_cnt_q + 2'd1;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Held byte moves to the shifter and the start bit goes out
    // on the same edge, so consecutive frames have no idle gap.
    if (load) begin
      shifter_d   = hold_q;
      hold_full_d = 1'b0;
      tx_d        = 1'b0;
      timer_d     = '0;
      state_d     = START;
    end
  end

endmodule

// File: tb/tb_midi_byte_tx.sv
// Testbench for midi_byte_tx: frame vectors, hand sequences,
// and random bytes decoded by a line receiver model.
module tb_midi_byte_tx;

  logic clk = 1'b0;
  logic reset;
  logic tx1, busy1, tx4, busy4;

  midi_byte_tx_if bus1 ();
  midi_byte_tx_if bus4 ();

  midi_byte_tx dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1),
    .tx    (tx1),
    .busy  (busy1)
  );

  midi_byte_tx #(.CLKS_PER_BIT(4)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4),
    .tx    (tx4),
    .busy  (busy4)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0]  data;
    logic [10:0] frame;
  } vec_t;

  vec_t vecs[8];

  logic [7:0] exp_q[$];
  bit         rx_en = 1'b0;
  int         rx_pos = 0;
  int         rx_cnt = 0;
  logic [7:0] rx_byte;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Receiver model for the CLKS_PER_BIT=1 line: one sample per bit.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rx_en || reset) begin
        rx_pos = 0;
      end else if (rx_pos == 0) begin
        if (tx1 == 1'b0) rx_pos = 1;
      end else if (rx_pos <= 8) begin
        rx_byte[rx_pos-1] = tx1;
        rx_pos++;
      end else if (rx_pos == 9) begin
        chk("rx_stop1", tx1, 1);
        rx_pos = 10;
      end else begin
        chk("rx_stop2", tx1, 1);
        rx_pos = 0;
        rx_cnt++;
        if (exp_q.size() == 0) begin
          chk("rx_unexpected", rx_byte, 32'hffff_ffff);
        end else begin
          chk("rx_byte", rx_byte, exp_q.pop_front());
        end
      end
    end
  end

  // One frame on dut1 from idle, every cycle compared to the vector.
  task automatic frame1(input logic [7:0] d,
                        input logic [10:0] f);
    bus1.data_in    = d;
    bus1.data_valid = 1'b1;
    tick();
    bus1.data_valid = 1'b0;
    chk("ready_low", bus1.data_ready, 0);
    chk("busy_held", busy1, 1);
    for (int k = 0; k < 11; k++) begin
      tick();
      chk("frame_bit", tx1, f[10-k]);
      if (k == 0) chk("ready_back", bus1.data_ready, 1);
    end
    tick();
    chk("end_tx", tx1, 1);
    chk("end_busy", busy1, 0);
    chk("end_ready", bus1.data_ready, 1);
  endtask

  // Offer a byte with valid held; junk on data_in while not ready.
  task automatic offer1(input logic [7:0] d);
    bit done = 1'b0;
    bus1.data_valid = 1'b1;
    for (int n = 0; n < 100 && !done; n++) begin
      if (bus1.data_ready) begin
        bus1.data_in = d;
        exp_q.push_back(d);
        tick();
        done = 1'b1;
      end else begin
        bus1.data_in = 8'($urandom);
        tick();
      end
    end
    bus1.data_valid = 1'b0;
    if (!done) chk("offer_timeout", 0, 1);
  endtask

  task automatic drain();
    for (int n = 0; n < 400 && exp_q.size() != 0; n++) tick();
    chk("drain_left", exp_q.size(), 0);
    repeat (3) tick();
    chk("drain_busy", busy1, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [21:0] s;
    logic [21:0] exp22;
    int          base;

    vecs[0] = '{8'h3C, 11'b000_1111_0011};
    vecs[1] = '{8'h00, 11'b000_0000_0011};
    vecs[2] = '{8'hFF, 11'b011_1111_1111};
    vecs[3] = '{8'hA5, 11'b010_1001_0111};
    vecs[4] = '{8'h90, 11'b000_0010_0111};
    vecs[5] = '{8'h45, 11'b010_1000_1011};
    vecs[6] = '{8'h55, 11'b010_1010_1011};
    vecs[7] = '{8'h0F, 11'b011_1100_0011};

    bus1.data_in = '0;
    bus1.data_valid = 1'b0;
    bus4.data_in = '0;
    bus4.data_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_tx", tx1, 1);
    chk("rst_ready", bus1.data_ready, 1);
    chk("rst_busy", busy1, 0);
    tick();
    tick();
    reset = 1'b0;

    // Idle after reset.
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_tx", tx1, 1);
      chk("idle_ready", bus1.data_ready, 1);
      chk("idle_busy", busy1, 0);
      chk("idle_tx4", tx4, 1);
    end

    // Frame vectors, 0x3C first.
    for (int i = 0; i < 8; i++) begin
      frame1(vecs[i].data, vecs[i].frame);
      repeat (2) tick();
    end

    // Two bytes back to back with valid held high.
    rx_en = 1'b1;
    base  = rx_cnt;
    exp_q.push_back(8'h90);
    exp_q.push_back(8'h45);
    bus1.data_in    = 8'h90;
    bus1.data_valid = 1'b1;
    tick();
    bus1.data_in = 8'h45;
    for (int k = 0; k < 22; k++) begin
      tick();
      if (k == 1) bus1.data_valid = 1'b0;
      s[21-k] = tx1;
    end
    exp22 = {vecs[4].frame, vecs[5].frame};
    chk("b2b_stream", s, exp22);
    tick();
    chk("b2b_busy", busy1, 0);
    drain();
    chk("b2b_frames", rx_cnt - base, 2);

    // Slow line: each bit held 4 cycles.
    bus4.data_in    = 8'hA5;
    bus4.data_valid = 1'b1;
    tick();
    bus4.data_valid = 1'b0;
    for (int k = 0; k < 44; k++) begin
      tick();
      chk("slow_bit", tx4, vecs[3].frame[10-k/4]);
    end
    chk("slow_busy_last", busy4, 1);
    tick();
    chk("slow_busy", busy4, 0);
    chk("slow_tx_idle", tx4, 1);

    // Reset during data bit 3 of 0x55.
    rx_en = 1'b0;
    bus1.data_in    = 8'h55;
    bus1.data_valid = 1'b1;
    tick();
    bus1.data_valid = 1'b0;
    repeat (5) tick();
    chk("pre_rst_bit3", tx1, 0);
    chk("pre_rst_busy", busy1, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_tx", tx1, 1);
    chk("mid_rst_ready", bus1.data_ready, 1);
    chk("mid_rst_busy", busy1, 0);
    tick();
    reset = 1'b0;
    repeat (3) begin
      tick();
      chk("post_rst_tx", tx1, 1);
    end
    frame1(vecs[7].data, vecs[7].frame);

    // Three bytes offered continuously with toggling junk.
    rx_en = 1'b1;
    base  = rx_cnt;
    offer1(8'h11);
    offer1(8'h22);
    offer1(8'h33);
    drain();
    chk("three_frames", rx_cnt - base, 3);

    // Random bytes with random gaps.
    base = rx_cnt;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 12)) tick();
      offer1(8'($urandom));
    end
    drain();
    chk("rand_frames", rx_cnt - base, 40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
